uart_packet: RTL and testbench
==============================

# uart_packet

Parametrised packet UART with built-in baud generation, serialiser and deserialiser; successor to the fixed two-byte UART wrapper. TX sends a variable-length burst of up to TX_BYTES bytes from a flat vector. RX assembles bytes into a packet, closes the packet on an idle-line gap and presents it double-buffered with length and error status. Sits between the board pins and the packet-level controller logic.

## Interface
- CLK_HZ, 50000000, system clock frequency
- BAUD, 115200, line rate; DIV = round(CLK_HZ/BAUD) clocks per bit, DIV ≥ 4
- TX_BYTES, 2, max bytes per TX burst
- RX_BYTES, 50, max bytes per RX packet
- GAP_BITS, 16, idle bit-times that terminate an RX packet
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rx  in  1  serial input, asynchronous, idle high
- tx  out  1  serial output, idle high
- tx_start  in  1  request burst; accepted only when tx_ready=1
- tx_bits  in  TX_BYTES*8  burst data, byte 0 = bits [7:0], sent first
- tx_len  in  clog2(TX_BYTES+1)  byte count for the burst
- tx_ready  out  1  high when TX is idle and can accept
- rx_available  out  1  one-cycle pulse: new packet on rx_bits/rx_len
- rx_bits  out  RX_BYTES*8  packet data, byte 0 = bits [7:0]
- rx_len  out  clog2(RX_BYTES+1)  valid bytes in rx_bits
- rx_overflow  out  1  packet exceeded RX_BYTES; excess bytes dropped
- rx_frame_err  out  1  at least one byte had a low stop bit

## Operation
- Frame: 1 start (0), 8 data LSB first, [parity], 1 stop (1).
- Reset values: tx=1, tx_ready=1, rx_available=0, rx_bits=0, rx_len=0, rx_overflow=0, rx_frame_err=0; all FSMs to IDLE, counters 0. Reset mid-frame aborts immediately; tx goes high asynchronously.
- TX FSM: IDLE → START → DATA(8) → [PARITY] → STOP → (bytes remain ? START : IDLE).
- Accept: tx_start=1 and tx_ready=1; tx_bits and tx_len latched, so inputs may change afterwards. tx_len=0 is ignored (stays IDLE). tx_len>TX_BYTES is clamped to TX_BYTES. tx_start while busy is ignored.
- RX: rx passes through a 2-flop synchroniser. IDLE detects a falling edge, waits DIV/2 and re-samples; if high, it is a false start and the FSM returns to IDLE. Otherwise data is sampled every DIV cycles at bit centres, then [PARITY], then STOP.
- Stop bit low: byte discarded, packet frame_err set, FSM waits for line high before re-arming.
- Good byte: written to working buffer at index cnt, cnt+1. When cnt==RX_BYTES, the byte is discarded and packet overflow is set; cnt saturates.
- Any completed frame, good or bad, arms the gap counter. Counter reloads on each frame end; a start edge stops it.
- Gap expiry after GAP_BITS*DIV idle cycles commits the packet:
  - rx_bits ← working buffer, with bytes ≥ cnt set to 0.
  - rx_len ← cnt.
  - rx_overflow and rx_frame_err ← packet flags.
  - Working buffer, cnt and flags are cleared.
- The committed outputs stay constant until the next commit. A packet with only bad frames commits with rx_len=0.

## Timing
- TX: start bit drives tx on the cycle after acceptance. tx_ready=0 from that same cycle.
- Each bit lasts exactly DIV cycles. Consecutive bytes are back-to-back, with no idle between stop and the next start.
- tx_ready returns to 1 on the cycle after the last stop bit's DIV cycles. Burst = tx_len*10*DIV cycles (11 with parity).
- RX data and flags commit in the same cycle that rx_available pulses; the pulse is exactly 1 cycle.
- Commit occurs GAP_BITS*DIV cycles (±1) after the stop-bit sample point of the last frame.
- Start edge to sample point: 2 synchroniser cycles + DIV/2, then DIV per bit.
- TX and RX are fully independent; simultaneous activity, including loopback, is legal.

## Configuration
- UART_PARITY_EN defined: an even-parity bit is sent after the data bits and checked on RX. A mismatch is treated as a frame error (byte discarded, rx_frame_err set). The frame is 11 bits.
- UART_PARITY_EN undefined: no parity bit; 10-bit frame.

## Test plan
All scenarios use CLK_HZ=1000000, BAUD=100000 (DIV=10), TX_BYTES=4, RX_BYTES=4, GAP_BITS=16, and rx looped from tx unless noted.
- **TX burst:** tx_bits=0xA5C3_1234, tx_len=2 → tx carries 0x34, then 0x12; bit cells 10 clocks each; tx_ready low for exactly 200 cycles; no further bytes.
- **Loopback packet:** tx_len=3 → one rx_available pulse about 160 cycles after the last stop; rx_len=3; rx_bits=0x00C3_1234.
- **Overflow:** drive 6 bytes 0x01..0x06 on rx → rx_len=4, rx_bits=0x0403_0201, rx_overflow=1. The following clean packet clears rx_overflow.
- **Frame error / false start:** byte 0x55 with stop=0 → rx_len=0, rx_frame_err=1. A 3-cycle low glitch on rx → no byte and no pulse.
- **Busy/clamp:** tx_start during a burst → ignored. tx_len=7 → 4 bytes sent. tx_len=0 → tx_ready stays 1.
- **Reset mid-operation:** rst_n low mid-byte in both directions → tx=1 and tx_ready=1 immediately; no rx_available pulse; next packet is received correctly.

Source files
------------

// File: rtl/uart_packet.sv
// uart_packet: packet UART with built-in baud generation, burst TX and gap-delimited, double-buffered RX.
// Optional even parity on both directions when UART_PARITY_EN is defined (11-bit frame).
module uart_packet #(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned TX_BYTES = 2,
  parameter int unsigned RX_BYTES = 50,
  parameter int unsigned GAP_BITS = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rx,
  output logic                            tx,
  input  logic                            tx_start,
  input  logic [TX_BYTES*8-1:0]           tx_bits,
  input  logic [$clog2(TX_BYTES+1)-1:0]   tx_len,
  output logic                            tx_ready,
  output logic                            rx_available,
  output logic [RX_BYTES*8-1:0]           rx_bits,
  output logic [$clog2(RX_BYTES+1)-1:0]   rx_len,
  output logic                            rx_overflow,
  output logic                            rx_frame_err
);
  localparam int unsigned DIV  = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned GAP  = GAP_BITS * DIV;
  localparam int unsigned BW   = $clog2(DIV);
  localparam int unsigned GW   = $clog2(GAP + 1);
  localparam int unsigned TLW  = $clog2(TX_BYTES + 1);
  localparam int unsigned RLW  = $clog2(RX_BYTES + 1);

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;

  tx_state_t             t_state, t_state_d;
  logic [BW-1:0]         t_baud, t_baud_d;
  logic [2:0]            t_bit, t_bit_d;
  logic [TLW-1:0]        t_left, t_left_d;
  logic [TX_BYTES*8-1:0] t_data, t_data_d;
  logic                  tx_q, tx_d;
  logic [TLW-1:0]        len_clamped;
  logic                  t_tick;
`ifdef UART_PARITY_EN
  logic                  t_par, t_par_d;
`endif

  assign len_clamped = (tx_len > TLW'(TX_BYTES)) ? TLW'(TX_BYTES) : tx_len;
  assign t_tick      = (t_baud == BW'(DIV - 1));
  assign tx          = tx_q;
  assign tx_ready    = (t_state == T_IDLE);

  // The burst register shifts right one bit per data bit, so the next byte
  // is already aligned at [7:0] when its start bit begins.
  always_comb begin
    t_state_d = t_state;
    t_baud_d  = t_baud + BW'(1);
    t_bit_d   = t_bit;
    t_left_d  = t_left;
    t_data_d  = t_data;
    tx_d      = tx_q;
`ifdef UART_PARITY_EN
    t_par_d   = t_par;
`endif
    unique case (t_state)
      T_IDLE: begin
        t_baud_d = '0;
        if (tx_start && len_clamped != '0) begin
          t_state_d = T_START;
          t_data_d  = tx_bits;
          t_left_d  = len_clamped;
          tx_d      = 1'b0;
        end
      end
      T_START: begin
        if (t_tick) begin
          t_baud_d  = '0;
          t_bit_d   = '0;
          t_state_d = T_DATA;
          tx_d      = t_data[0];
`ifdef UART_PARITY_EN
          t_par_d   = ^t_data[7:0];
`endif
        end
      end
      T_DATA: begin
        if (t_tick) begin
          t_baud_d = '0;
          t_data_d = t_data >> 1;
          t_bit_d  = t_bit + 3'd1;
          if (t_bit == 3'd7) begin
`ifdef UART_PARITY_EN
            t_state_d = T_PARITY;
            tx_d      = t_par;
`else
            t_state_d = T_STOP;
            tx_d      = 1'b1;
`endif
          end else begin
            tx_d = t_data[1];
          end
        end
      end
      T_PARITY: begin
        if (t_tick) begin
          t_baud_d  = '0;
          t_state_d = T_STOP;
          tx_d      = 1'b1;
        end
      end
      T_STOP: begin
        if (t_tick) begin
          t_baud_d = '0;
          t_left_d = t_left - TLW'(1);
          if (t_left == TLW'(1)) begin
            t_state_d = T_IDLE;
            tx_d      = 1'b1;
          end else begin
            t_state_d = T_START;
            tx_d      = 1'b0;
          end
        end
      end
      default: begin
        t_state_d = T_IDLE;
        tx_d      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_state <= T_IDLE;
      t_baud  <= '0;
      t_bit   <= '0;
      t_left  <= '0;
      t_data  <= '0;
      tx_q    <= 1'b1;
`ifdef UART_PARITY_EN
      t_par   <= 1'b0;
`endif
    end else begin
      t_state <= t_state_d;
      t_baud  <= t_baud_d;
      t_bit   <= t_bit_d;
      t_left  <= t_left_d;
      t_data  <= t_data_d;
      tx_q    <= tx_d;
`ifdef UART_PARITY_EN
      t_par   <= t_par_d;
`endif
    end
  end

  // ---------------------------------------------------------------- RX
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_WAIT} rx_state_t;

  logic                  rx_s1, rx_s2, rx_s3;
  rx_state_t             r_state, r_state_d;
  logic [BW-1:0]         r_baud, r_baud_d;
  logic [2:0]            r_bit, r_bit_d;
  logic [7:0]            r_shift;
  logic                  r_tick;
  logic                  shift_en, frame_end, frame_good, par_ok;
  logic [RX_BYTES*8-1:0] wbuf;
  logic [RLW-1:0]        cnt;
  logic                  p_ovf, p_ferr;
  logic [GW-1:0]         gap_cnt;
  logic                  gap_run, commit;
`ifdef UART_PARITY_EN
  logic                  par_sample, r_par_err;
`endif

  assign r_tick = (r_baud == BW'(DIV - 1));
  assign commit = gap_run && (r_state == R_IDLE) && (gap_cnt == GW'(GAP - 1));

`ifdef UART_PARITY_EN
  assign par_ok = !r_par_err;
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    r_state_d  = r_state;
    r_baud_d   = r_baud + BW'(1);
    r_bit_d    = r_bit;
    shift_en   = 1'b0;
    frame_end  = 1'b0;
    frame_good = 1'b0;
`ifdef UART_PARITY_EN
    par_sample = 1'b0;
`endif
    unique case (r_state)
      R_IDLE: begin
        r_baud_d = '0;
        if (rx_s3 && !rx_s2) r_state_d = R_START;
      end
      R_START: begin
        if (r_baud == BW'(HALF - 1)) begin
          r_baud_d  = '0;
          r_bit_d   = '0;
          r_state_d = rx_s2 ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (r_tick) begin
          r_baud_d = '0;
          shift_en = 1'b1;
          r_bit_d  = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
            r_state_d = R_PARITY;
`else
            r_state_d = R_STOP;
`endif
          end
        end
      end
      R_PARITY: begin
        if (r_tick) begin
          r_baud_d  = '0;
          r_state_d = R_STOP;
`ifdef UART_PARITY_EN
          par_sample = 1'b1;
`endif
        end
      end
      R_STOP: begin
        if (r_tick) begin
          r_baud_d   = '0;
          frame_end  = 1'b1;
          frame_good = rx_s2 && par_ok;
          r_state_d  = rx_s2 ? R_IDLE : R_WAIT;
        end
      end
      R_WAIT: begin
        r_baud_d = '0;
        if (rx_s2) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_s3   <= 1'b1;
      r_state <= R_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_s3   <= rx_s2;
      r_state <= r_state_d;
      r_baud  <= r_baud_d;
      r_bit   <= r_bit_d;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_par_err <= 1'b0;
    else if (par_sample) r_par_err <= rx_s2 ^ (^r_shift);
  end
`endif

  // The gap timer only advances while the line is idle, so a false start
  // pauses it without losing a pending packet. Bytes at index >= cnt are
  // never written and are cleared on commit, so rx_bits needs no masking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift      <= '0;
      wbuf         <= '0;
      cnt          <= '0;
      p_ovf        <= 1'b0;
      p_ferr       <= 1'b0;
      gap_cnt      <= '0;
      gap_run      <= 1'b0;
      rx_available <= 1'b0;
      rx_bits      <= '0;
      rx_len       <= '0;
      rx_overflow  <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_available <= commit;
      if (shift_en) r_shift <= {rx_s2, r_shift[7:1]};
      if (frame_end) begin
        gap_cnt <= '0;
        gap_run <= 1'b1;
        if (!frame_good) begin
          p_ferr <= 1'b1;
        end else if (cnt == RLW'(RX_BYTES)) begin
          p_ovf <= 1'b1;
        end else begin
          for (int unsigned i = 0; i < RX_BYTES; i++)
            if (cnt == RLW'(i)) wbuf[i*8 +: 8] <= r_shift;
          cnt <= cnt + RLW'(1);
        end
      end else if (commit) begin
        rx_bits      <= wbuf;
        rx_len       <= cnt;
        rx_overflow  <= p_ovf;
        rx_frame_err <= p_ferr;
        wbuf         <= '0;
        cnt          <= '0;
        p_ovf        <= 1'b0;
        p_ferr       <= 1'b0;
        gap_run      <= 1'b0;
        gap_cnt      <= '0;
      end else if (gap_run && r_state == R_IDLE) begin
        gap_cnt <= gap_cnt + GW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_packet.sv
// tb_uart_packet: directed self-checking bench for uart_packet (DIV=10, 4-byte TX/RX, 16-bit gap).
module tb_uart_packet;
  logic        clk;
  logic        rst_n;
  logic        rx_line, rx_drv, loop_en;
  logic        tx;
  logic        tx_start;
  logic [31:0] tx_bits;
  logic [2:0]  tx_len;
  logic        tx_ready;
  logic        rx_available;
  logic [31:0] rx_bits;
  logic [2:0]  rx_len;
  logic        rx_overflow;
  logic        rx_frame_err;

  int n_checks = 0;
  int n_bad    = 0;
  int pulse_cnt = 0;

  assign rx_line = loop_en ? tx : rx_drv;

  uart_packet #(
    .CLK_HZ(1000000), .BAUD(100000), .TX_BYTES(4), .RX_BYTES(4), .GAP_BITS(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx_line), .tx(tx),
    .tx_start(tx_start), .tx_bits(tx_bits), .tx_len(tx_len), .tx_ready(tx_ready),
    .rx_available(rx_available), .rx_bits(rx_bits), .rx_len(rx_len),
    .rx_overflow(rx_overflow), .rx_frame_err(rx_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && rx_available) pulse_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue a burst, record tx every cycle while busy, decode the frames and
  // verify the line stays idle afterwards.
  task automatic run_burst(input logic [31:0] bits, input logic [2:0] len, input int poke_at,
                           output int low, output logic [31:0] data, output int bad_cells);
    logic smp [0:599];
    int   nb;
    @(negedge clk);
    tx_bits = bits; tx_len = len; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    low = 0;
    for (int i = 0; i < 600 && !tx_ready; i++) begin
      smp[i] = tx;
      low++;
      if (i == poke_at) begin
        tx_start = 1'b1; tx_bits = '1; tx_len = 3'd4;
      end else if (i == poke_at + 1) begin
        tx_start = 1'b0;
      end
      @(negedge clk);
    end
    data = '0; bad_cells = 0;
    for (int c = 0; c < low / 10; c++)
      for (int s = 0; s < 10; s++)
        if (smp[c*10+s] !== smp[c*10+5]) bad_cells++;
    nb = low / 100;
    for (int j = 0; j < nb && j < 4; j++) begin
      if (smp[(j*10)*10+5] !== 1'b0) bad_cells++;
      if (smp[(j*10+9)*10+5] !== 1'b1) bad_cells++;
      for (int b = 0; b < 8; b++) data[j*8+b] = smp[(j*10+1+b)*10+5];
    end
    for (int i = 0; i < 30; i++) begin
      if (tx !== 1'b1) bad_cells++;
      @(negedge clk);
    end
  endtask

  task automatic wait_pulse(input int budget, output logic ok, output int cyc);
    ok = 1'b0; cyc = 0;
    while (!ok && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (rx_available) ok = 1'b1;
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_drv = fr[k];
      repeat (10) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  int          low, bad_cells, cyc, p0;
  logic [31:0] data;
  logic        ok;

  initial begin
    rst_n = 1'b0; tx_start = 1'b0; tx_bits = '0; tx_len = '0;
    rx_drv = 1'b1; loop_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_available", rx_available, 1'b0);
    check("rst_rx_bits", rx_bits, 32'h0);
    check("rst_rx_len", rx_len, 3'd0);
    check("rst_rx_overflow", rx_overflow, 1'b0);
    check("rst_rx_frame_err", rx_frame_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // TX burst of two bytes, looped back
    run_burst(32'hA5C3_1234, 3'd2, -1, low, data, bad_cells);
    check("burst2_busy_cycles", low, 200);
    check("burst2_bytes", data[15:0], 16'h1234);
    check("burst2_cells", bad_cells, 0);
    wait_pulse(400, ok, cyc);
    check("burst2_pulse_seen", ok, 1'b1);
    check("burst2_rx_len", rx_len, 3'd2);
    check("burst2_rx_bits", rx_bits, 32'h0000_1234);

    // Loopback packet of three bytes with gap timing and single pulse
    repeat (5) @(negedge clk);
    p0 = pulse_cnt;
    run_burst(32'hA5C3_1234, 3'd3, -1, low, data, bad_cells);
    check("loop3_busy_cycles", low, 300);
    check("loop3_bytes", data[23:0], 24'hC3_1234);
    wait_pulse(400, ok, cyc);
    check("loop3_pulse_seen", ok, 1'b1);
    check("loop3_gap_window", (30 + cyc >= 150) && (30 + cyc <= 170), 1'b1);
    repeat (20) @(negedge clk);
    check("loop3_pulse_count", pulse_cnt - p0, 1);
    check("loop3_rx_len", rx_len, 3'd3);
    check("loop3_rx_bits", rx_bits, 32'h00C3_1234);
    check("loop3_overflow", rx_overflow, 1'b0);
    check("loop3_frame_err", rx_frame_err, 1'b0);

    // Overflow: six bytes driven directly on rx
    loop_en = 1'b0;
    for (int i = 1; i <= 6; i++) rx_send(8'(i), 1'b1);
    wait_pulse(400, ok, cyc);
    check("ovf_pulse_seen", ok, 1'b1);
    check("ovf_rx_len", rx_len, 3'd4);
    check("ovf_rx_bits", rx_bits, 32'h0403_0201);
    check("ovf_flag", rx_overflow, 1'b1);
    rx_send(8'h77, 1'b1);
    wait_pulse(400, ok, cyc);
    check("clean_pulse_seen", ok, 1'b1);
    check("clean_rx_len", rx_len, 3'd1);
    check("clean_rx_bits", rx_bits, 32'h0000_0077);
    check("clean_overflow", rx_overflow, 1'b0);

    // Frame error, then a short glitch that must be rejected
    rx_send(8'h55, 1'b0);
    wait_pulse(400, ok, cyc);
    check("ferr_pulse_seen", ok, 1'b1);
    check("ferr_rx_len", rx_len, 3'd0);
    check("ferr_rx_bits", rx_bits, 32'h0);
    check("ferr_flag", rx_frame_err, 1'b1);
    repeat (5) @(negedge clk);
    p0 = pulse_cnt;
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch_no_pulse", pulse_cnt - p0, 0);
    rx_send(8'h3C, 1'b1);
    wait_pulse(400, ok, cyc);
    check("post_glitch_rx_len", rx_len, 3'd1);
    check("post_glitch_rx_bits", rx_bits, 32'h0000_003C);
    check("post_glitch_frame_err", rx_frame_err, 1'b0);

    // Busy start ignored, length clamp, zero length
    loop_en = 1'b1;
    run_burst(32'hA5C3_1234, 3'd2, 50, low, data, bad_cells);
    check("busy_busy_cycles", low, 200);
    check("busy_bytes", data[15:0], 16'h1234);
    check("busy_cells", bad_cells, 0);
    wait_pulse(400, ok, cyc);
    check("busy_rx_len", rx_len, 3'd2);
    run_burst(32'hA5C3_1234, 3'd7, -1, low, data, bad_cells);
    check("clamp_busy_cycles", low, 400);
    check("clamp_bytes", data, 32'hA5C3_1234);
    check("clamp_cells", bad_cells, 0);
    wait_pulse(400, ok, cyc);
    check("clamp_rx_len", rx_len, 3'd4);
    check("clamp_rx_bits", rx_bits, 32'hA5C3_1234);
    check("clamp_overflow", rx_overflow, 1'b0);
    @(negedge clk);
    tx_bits = 32'h0000_00FF; tx_len = 3'd0; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check("len0_tx_ready", tx_ready, 1'b1);
    repeat (15) @(negedge clk);
    check("len0_tx_idle", tx, 1'b1);
    check("len0_tx_ready_later", tx_ready, 1'b1);

    // Reset in the middle of a looped-back byte
    p0 = pulse_cnt;
    @(negedge clk);
    tx_bits = 32'h0000_1234; tx_len = 3'd2; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (45) @(negedge clk);
    check("mid_busy", tx_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_tx_ready", tx_ready, 1'b1);
    check("mid_rst_rx_len", rx_len, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("mid_rst_no_pulse", pulse_cnt - p0, 0);
    run_burst(32'h0000_BEEF, 3'd2, -1, low, data, bad_cells);
    check("after_rst_busy_cycles", low, 200);
    wait_pulse(400, ok, cyc);
    check("after_rst_pulse_seen", ok, 1'b1);
    check("after_rst_rx_len", rx_len, 3'd2);
    check("after_rst_rx_bits", rx_bits, 32'h0000_BEEF);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
